// File: rtl/pkg_wr_ctrl.sv
// Write-side packet controller for the dual-priority packet RAMs.
// Byte-serial packets are steered into the high RAM (qos=1) or the low
// RAM (qos=0). Each RAM has a working pointer (wp) and a committed pointer
// (real_waddr). Only complete, validated packets move real_waddr. Packets
// that overflow, are oversize or undersize, or are malformed are rolled
// back to the committed pointer and counted in drop_cnt.
//
// Ports:
//   clk, rst_n                     clock, synchronous active-low reset
//   pkt_vld_in/pkt_data_in         input byte stream (always accepted)
//   pkt_sop_in/pkt_eop_in          packet delimiters, qualified by vld
//   pkt_qos_in/pkt_id_in           target RAM and destination id, taken at sop
//   pkt_rdy_out                    tied high; overflow drops, never stalls
//   hram_raddr/lram_raddr          reader pointers for the full check
//   hram_wen/waddr/wdata           high RAM write port (same cycle as byte)
//   lram_wen/waddr/wdata           low RAM write port (same cycle as byte)
//   high_real_waddr/low_real_waddr committed write pointers for the reader
//   drop_cnt                       saturating dropped-packet counter
//   busy                           FSM is not idle
module pkg_wr_ctrl #(
  parameter int unsigned RAM_DEPTH   = 1144,
  parameter int unsigned ADDR_WIDTH  = 11,
  parameter int unsigned MAX_PKT_LEN = 1024,
  parameter int unsigned MIN_PKT_LEN = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  pkt_vld_in,
  input  logic [7:0]            pkt_data_in,
  input  logic                  pkt_sop_in,
  input  logic                  pkt_eop_in,
  input  logic                  pkt_qos_in,
  input  logic [2:0]            pkt_id_in,
  output logic                  pkt_rdy_out,
  input  logic [ADDR_WIDTH-1:0] hram_raddr,
  input  logic [ADDR_WIDTH-1:0] lram_raddr,
  output logic                  hram_wen,
  output logic [ADDR_WIDTH-1:0] hram_waddr,
  output logic [10:0]           hram_wdata,
  output logic                  lram_wen,
  output logic [ADDR_WIDTH-1:0] lram_waddr,
  output logic [10:0]           lram_wdata,
  output logic [ADDR_WIDTH-1:0] high_real_waddr,
  output logic [ADDR_WIDTH-1:0] low_real_waddr,
  output logic [15:0]           drop_cnt,
  output logic                  busy
);

  localparam int unsigned LEN_W = $clog2(MAX_PKT_LEN + 2);
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(RAM_DEPTH - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_WRITE, ST_DROP} state_t;

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   hwp_q, hwp_d, lwp_q, lwp_d;
  logic [ADDR_WIDTH-1:0]   hreal_q, hreal_d, lreal_q, lreal_d;
  logic                    qos_q, qos_d;
  logic [LEN_W-1:0]        len_q, len_d, len_inc;
  logic [15:0]             drop_q, drop_d;
  logic [16:0]             drop_sum;
  logic [1:0]              drop_inc;
  logic                    hwen_c, lwen_c;
  logic [ADDR_WIDTH-1:0]   hwaddr_c, lwaddr_c;
  logic [10:0]             word_c;
  logic                    start_new, new_full, cur_full;
  logic [ADDR_WIDTH-1:0]   new_wp;

  // Circular pointer increment, wrapping at RAM_DEPTH-1.
  function automatic logic [ADDR_WIDTH-1:0] ptr_inc(input logic [ADDR_WIDTH-1:0] p);
    return (p == LAST_ADDR) ? '0 : p + ADDR_WIDTH'(1);
  endfunction

  // State and pointer registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      hwp_q   <= '0;
      lwp_q   <= '0;
      hreal_q <= '0;
      lreal_q <= '0;
      qos_q   <= 1'b0;
      len_q   <= '0;
      drop_q  <= '0;
    end else begin
      state_q <= state_d;
      hwp_q   <= hwp_d;
      lwp_q   <= lwp_d;
      hreal_q <= hreal_d;
      lreal_q <= lreal_d;
      qos_q   <= qos_d;
      len_q   <= len_d;
      drop_q  <= drop_d;
    end
  end

  // Next-state, pointer update and same-cycle RAM write decode.
  always_comb begin
    state_d   = state_q;
    hwp_d     = hwp_q;
    lwp_d     = lwp_q;
    hreal_d   = hreal_q;
    lreal_d   = lreal_q;
    qos_d     = qos_q;
    len_d     = len_q;
    drop_inc  = 2'd0;
    hwen_c    = 1'b0;
    lwen_c    = 1'b0;
    hwaddr_c  = hwp_q;
    lwaddr_c  = lwp_q;
    word_c    = '0;
    start_new = 1'b0;
    new_wp    = '0;
    new_full  = 1'b0;
    cur_full  = 1'b0;
    len_inc   = len_q + LEN_W'(1);

    if (rst_n && pkt_vld_in) begin
      unique case (state_q)
        ST_WRITE: begin
          cur_full = qos_q ? (ptr_inc(hwp_q) == hram_raddr)
                           : (ptr_inc(lwp_q) == lram_raddr);
          if (pkt_sop_in) begin
            // Missing eop: discard the open packet, then restart on this byte.
            if (qos_q) hwp_d = hreal_q;
            else       lwp_d = lreal_q;
            drop_inc  = 2'd1;
            start_new = 1'b1;
          end else if (cur_full || (len_inc > LEN_W'(MAX_PKT_LEN)) ||
                       (pkt_eop_in && (len_inc < LEN_W'(MIN_PKT_LEN)))) begin
            if (qos_q) hwp_d = hreal_q;
            else       lwp_d = lreal_q;
            drop_inc = 2'd1;
            state_d  = pkt_eop_in ? ST_IDLE : ST_DROP;
          end else begin
            word_c = {2'b00, pkt_eop_in, pkt_data_in};
            len_d  = len_inc;
            if (qos_q) begin
              hwen_c = 1'b1;
              hwp_d  = ptr_inc(hwp_q);
              if (pkt_eop_in) hreal_d = hwp_d;
            end else begin
              lwen_c = 1'b1;
              lwp_d  = ptr_inc(lwp_q);
              if (pkt_eop_in) lreal_d = lwp_d;
            end
            if (pkt_eop_in) state_d = ST_IDLE;
          end
        end
        default: begin
          // ST_IDLE and ST_DROP: only a sop starts anything.
          if (pkt_sop_in)      start_new = 1'b1;
          else if (pkt_eop_in) state_d   = ST_IDLE;
        end
      endcase

      // New packet start, using the pointer after any rollback above.
      if (start_new) begin
        new_wp   = pkt_qos_in ? hwp_d : lwp_d;
        new_full = (ptr_inc(new_wp) == (pkt_qos_in ? hram_raddr : lram_raddr));
        if ((pkt_eop_in && (MIN_PKT_LEN > 1)) || new_full) begin
          drop_inc = drop_inc + 2'd1;
          state_d  = pkt_eop_in ? ST_IDLE : ST_DROP;
        end else begin
          word_c  = {pkt_id_in, pkt_data_in};
          qos_d   = pkt_qos_in;
          len_d   = LEN_W'(1);
          state_d = pkt_eop_in ? ST_IDLE : ST_WRITE;
          if (pkt_qos_in) begin
            hwen_c   = 1'b1;
            hwaddr_c = new_wp;
            hwp_d    = ptr_inc(new_wp);
            if (pkt_eop_in) hreal_d = hwp_d;
          end else begin
            lwen_c   = 1'b1;
            lwaddr_c = new_wp;
            lwp_d    = ptr_inc(new_wp);
            if (pkt_eop_in) lreal_d = lwp_d;
          end
        end
      end
    end

    // Saturating drop counter; up to two drops can land in one cycle.
    drop_sum = {1'b0, drop_q} + 17'(drop_inc);
    drop_d   = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
  end

  assign pkt_rdy_out     = 1'b1;
  assign hram_wen        = hwen_c;
  assign hram_waddr      = hwaddr_c;
  assign hram_wdata      = hwen_c ? word_c : '0;
  assign lram_wen        = lwen_c;
  assign lram_waddr      = lwaddr_c;
  assign lram_wdata      = lwen_c ? word_c : '0;
  assign high_real_waddr = hreal_q;
  assign low_real_waddr  = lreal_q;
  assign drop_cnt        = drop_q;
  assign busy            = (state_q != ST_IDLE);

endmodule

// File: tb/tb_pkg_wr_ctrl.sv
// Directed bench for pkg_wr_ctrl, built with MAX_PKT_LEN = 8.
module tb_pkg_wr_ctrl;

  localparam logic T = 1'b1;
  localparam logic F = 1'b0;

  logic        clk;
  logic        rst_n;
  logic        pkt_vld_in;
  logic [7:0]  pkt_data_in;
  logic        pkt_sop_in;
  logic        pkt_eop_in;
  logic        pkt_qos_in;
  logic [2:0]  pkt_id_in;
  logic        pkt_rdy_out;
  logic [10:0] hram_raddr;
  logic [10:0] lram_raddr;
  logic        hram_wen;
  logic [10:0] hram_waddr;
  logic [10:0] hram_wdata;
  logic        lram_wen;
  logic [10:0] lram_waddr;
  logic [10:0] lram_wdata;
  logic [10:0] high_real_waddr;
  logic [10:0] low_real_waddr;
  logic [15:0] drop_cnt;
  logic        busy;

  int n_cmp;
  int n_fail;

  pkg_wr_ctrl #(.MAX_PKT_LEN(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .pkt_vld_in(pkt_vld_in), .pkt_data_in(pkt_data_in),
    .pkt_sop_in(pkt_sop_in), .pkt_eop_in(pkt_eop_in),
    .pkt_qos_in(pkt_qos_in), .pkt_id_in(pkt_id_in),
    .pkt_rdy_out(pkt_rdy_out),
    .hram_raddr(hram_raddr), .lram_raddr(lram_raddr),
    .hram_wen(hram_wen), .hram_waddr(hram_waddr), .hram_wdata(hram_wdata),
    .lram_wen(lram_wen), .lram_waddr(lram_waddr), .lram_wdata(lram_wdata),
    .high_real_waddr(high_real_waddr), .low_real_waddr(low_real_waddr),
    .drop_cnt(drop_cnt), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        vld, sop, eop, qos;
    logic [2:0]  id;
    logic [7:0]  data;
    logic        hwen, lwen;
    logic [10:0] addr, wdata, hreal, lreal;
    logic [15:0] drop;
    logic        bsy;
  } vec_t;

  function automatic vec_t mk(input logic vld, sop, eop, qos, input logic [2:0] id,
                              input logic [7:0] data, input logic hw, lw,
                              input logic [10:0] addr, wd, hr, lr,
                              input logic [15:0] drp, input logic bsy);
    vec_t v;
    v.vld = vld; v.sop = sop; v.eop = eop; v.qos = qos; v.id = id; v.data = data;
    v.hwen = hw; v.lwen = lw; v.addr = addr; v.wdata = wd;
    v.hreal = hr; v.lreal = lr; v.drop = drp; v.bsy = bsy;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Drive one byte at negedge, check the same-cycle write port, then the
  // registered state just after the following posedge.
  task automatic apply_vec(input string tag, input vec_t v);
    @(negedge clk);
    pkt_vld_in  = v.vld;
    pkt_sop_in  = v.sop;
    pkt_eop_in  = v.eop;
    pkt_qos_in  = v.qos;
    pkt_id_in   = v.id;
    pkt_data_in = v.data;
    #1;
    chk({tag, ".hwen"}, 32'(hram_wen), 32'(v.hwen));
    chk({tag, ".lwen"}, 32'(lram_wen), 32'(v.lwen));
    if (v.hwen) begin
      chk({tag, ".hwaddr"}, 32'(hram_waddr), 32'(v.addr));
      chk({tag, ".hwdata"}, 32'(hram_wdata), 32'(v.wdata));
    end
    if (v.lwen) begin
      chk({tag, ".lwaddr"}, 32'(lram_waddr), 32'(v.addr));
      chk({tag, ".lwdata"}, 32'(lram_wdata), 32'(v.wdata));
    end
    @(posedge clk);
    #1;
    pkt_vld_in = 1'b0;
    chk({tag, ".hreal"}, 32'(high_real_waddr), 32'(v.hreal));
    chk({tag, ".lreal"}, 32'(low_real_waddr), 32'(v.lreal));
    chk({tag, ".drop"}, 32'(drop_cnt), 32'(v.drop));
    chk({tag, ".busy"}, 32'(busy), 32'(v.bsy));
  endtask

  task automatic drive_byte(input logic sop, eop, qos, input logic [2:0] id,
                            input logic [7:0] data);
    @(negedge clk);
    pkt_vld_in  = 1'b1;
    pkt_sop_in  = sop;
    pkt_eop_in  = eop;
    pkt_qos_in  = qos;
    pkt_id_in   = id;
    pkt_data_in = data;
    @(posedge clk);
    #1;
    pkt_vld_in = 1'b0;
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk);
    rst_n      = 1'b0;
    pkt_vld_in = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk({tag, ".rdy"}, 32'(pkt_rdy_out), 32'd1);
    chk({tag, ".busy"}, 32'(busy), 32'd0);
    chk({tag, ".hreal"}, 32'(high_real_waddr), 32'd0);
    chk({tag, ".lreal"}, 32'(low_real_waddr), 32'd0);
    chk({tag, ".drop"}, 32'(drop_cnt), 32'd0);
    chk({tag, ".hwen"}, 32'(hram_wen), 32'd0);
    chk({tag, ".hwaddr"}, 32'(hram_waddr), 32'd0);
    chk({tag, ".lwaddr"}, 32'(lram_waddr), 32'd0);
  endtask

  vec_t tbl[31];

  initial begin
    n_cmp = 0;
    n_fail = 0;
    rst_n = 1'b0;
    pkt_vld_in = 1'b0; pkt_sop_in = 1'b0; pkt_eop_in = 1'b0;
    pkt_qos_in = 1'b0; pkt_id_in = '0; pkt_data_in = '0;
    hram_raddr = '0; lram_raddr = '0;

    // 4-byte high packet, id 5
    tbl[0]  = mk(T,T,F,T,3'd5,8'h11, T,F,11'd0,11'h511, 11'd0,11'd0,16'd0,T);
    tbl[1]  = mk(T,F,F,T,3'd0,8'h22, T,F,11'd1,11'h022, 11'd0,11'd0,16'd0,T);
    tbl[2]  = mk(T,F,F,T,3'd0,8'h33, T,F,11'd2,11'h033, 11'd0,11'd0,16'd0,T);
    tbl[3]  = mk(T,F,T,T,3'd0,8'h44, T,F,11'd3,11'h144, 11'd4,11'd0,16'd0,F);
    // 3-byte low packet then 2-byte high packet
    tbl[4]  = mk(T,T,F,F,3'd3,8'hA1, F,T,11'd0,11'h3A1, 11'd4,11'd0,16'd0,T);
    tbl[5]  = mk(T,F,F,F,3'd0,8'hB2, F,T,11'd1,11'h0B2, 11'd4,11'd0,16'd0,T);
    tbl[6]  = mk(T,F,T,F,3'd0,8'hC3, F,T,11'd2,11'h1C3, 11'd4,11'd3,16'd0,F);
    tbl[7]  = mk(T,T,F,T,3'd2,8'h55, T,F,11'd4,11'h255, 11'd4,11'd3,16'd0,T);
    tbl[8]  = mk(T,F,T,T,3'd0,8'h66, T,F,11'd5,11'h166, 11'd6,11'd3,16'd0,F);
    // single-byte packet, then a byte without sop
    tbl[9]  = mk(T,T,T,T,3'd1,8'h77, F,F,11'd0,11'h000, 11'd6,11'd3,16'd1,F);
    tbl[10] = mk(T,F,F,T,3'd1,8'h88, F,F,11'd0,11'h000, 11'd6,11'd3,16'd1,F);
    // sop mid-packet on the same RAM: rollback to 6 and restart there
    tbl[11] = mk(T,T,F,T,3'd1,8'h01, T,F,11'd6,11'h101, 11'd6,11'd3,16'd1,T);
    tbl[12] = mk(T,F,F,T,3'd0,8'h02, T,F,11'd7,11'h002, 11'd6,11'd3,16'd1,T);
    tbl[13] = mk(T,T,F,T,3'd4,8'h10, T,F,11'd6,11'h410, 11'd6,11'd3,16'd2,T);
    tbl[14] = mk(T,F,T,T,3'd0,8'h20, T,F,11'd7,11'h120, 11'd8,11'd3,16'd2,F);
    // sop mid low packet starting a high packet: low wp rolls back to 3
    tbl[15] = mk(T,T,F,F,3'd6,8'h30, F,T,11'd3,11'h630, 11'd8,11'd3,16'd2,T);
    tbl[16] = mk(T,F,F,F,3'd0,8'h31, F,T,11'd4,11'h031, 11'd8,11'd3,16'd2,T);
    tbl[17] = mk(T,T,F,T,3'd7,8'h40, T,F,11'd8,11'h740, 11'd8,11'd3,16'd3,T);
    tbl[18] = mk(T,F,T,T,3'd0,8'h41, T,F,11'd9,11'h141, 11'd10,11'd3,16'd3,F);
    // 10-byte high packet, oversize on the 9th byte
    tbl[19] = mk(T,T,F,T,3'd0,8'h00, T,F,11'd10,11'h000, 11'd10,11'd3,16'd3,T);
    for (int k = 1; k <= 7; k++)
      tbl[19+k] = mk(T,F,F,T,3'd0,8'(k), T,F,11'(10+k),11'(k), 11'd10,11'd3,16'd3,T);
    tbl[27] = mk(T,F,F,T,3'd0,8'h08, F,F,11'd0,11'h000, 11'd10,11'd3,16'd4,T);
    tbl[28] = mk(T,F,T,T,3'd0,8'h09, F,F,11'd0,11'h000, 11'd10,11'd3,16'd4,F);
    // following 2-byte packet commits at the original start
    tbl[29] = mk(T,T,F,T,3'd2,8'hAA, T,F,11'd10,11'h2AA, 11'd10,11'd3,16'd4,T);
    tbl[30] = mk(T,F,T,T,3'd0,8'hBB, T,F,11'd11,11'h1BB, 11'd12,11'd3,16'd4,F);

    do_reset("rst0");
    for (int i = 0; i < 31; i++)
      apply_vec($sformatf("v%0d", i), tbl[i]);

    // Overflow: reader at 15, wp at 12 -> writes at 12,13 then full
    hram_raddr = 11'd15;
    apply_vec("ovf0", mk(T,T,F,T,3'd3,8'hD0, T,F,11'd12,11'h3D0, 11'd12,11'd3,16'd4,T));
    apply_vec("ovf1", mk(T,F,F,T,3'd0,8'hD1, T,F,11'd13,11'h0D1, 11'd12,11'd3,16'd4,T));
    apply_vec("ovf2", mk(T,F,F,T,3'd0,8'hD2, F,F,11'd0,11'h000, 11'd12,11'd3,16'd5,T));
    apply_vec("ovf3", mk(T,F,F,T,3'd0,8'hD3, F,F,11'd0,11'h000, 11'd12,11'd3,16'd5,T));
    apply_vec("ovf4", mk(T,F,F,T,3'd0,8'hD4, F,F,11'd0,11'h000, 11'd12,11'd3,16'd5,T));
    apply_vec("ovf5", mk(T,F,T,T,3'd0,8'hD5, F,F,11'd0,11'h000, 11'd12,11'd3,16'd5,F));
    apply_vec("ovf6", mk(T,T,F,T,3'd6,8'hE0, T,F,11'd12,11'h6E0, 11'd12,11'd3,16'd5,T));
    apply_vec("ovf7", mk(T,F,T,T,3'd0,8'hE1, T,F,11'd13,11'h1E1, 11'd14,11'd3,16'd5,F));

    // Reset in the middle of a low packet
    hram_raddr = 11'd0;
    apply_vec("mid0", mk(T,T,F,F,3'd1,8'hF0, F,T,11'd3,11'h1F0, 11'd14,11'd3,16'd5,T));
    do_reset("rst1");

    // Fill the high RAM to 1142 with 8-byte and 6-byte packets
    for (int p = 0; p < 142; p++)
      for (int b = 0; b < 8; b++)
        drive_byte(b == 0, b == 7, T, 3'd1, 8'(b));
    for (int b = 0; b < 6; b++)
      drive_byte(b == 0, b == 5, T, 3'd1, 8'(b));
    chk("fill.hreal", 32'(high_real_waddr), 32'd1142);
    chk("fill.drop", 32'(drop_cnt), 32'd0);

    // Wrap-around with reader at 1000
    hram_raddr = 11'd1000;
    apply_vec("wrap0", mk(T,T,F,T,3'd5,8'h11, T,F,11'd1142,11'h511, 11'd1142,11'd0,16'd0,T));
    apply_vec("wrap1", mk(T,F,F,T,3'd0,8'h22, T,F,11'd1143,11'h022, 11'd1142,11'd0,16'd0,T));
    apply_vec("wrap2", mk(T,F,F,T,3'd0,8'h33, T,F,11'd0,11'h033, 11'd1142,11'd0,16'd0,T));
    apply_vec("wrap3", mk(T,F,T,T,3'd0,8'h44, T,F,11'd1,11'h144, 11'd2,11'd0,16'd0,F));

    // Full exactly at sop: wp 2, reader 3
    hram_raddr = 11'd3;
    apply_vec("fsop0", mk(T,T,F,T,3'd0,8'h99, F,F,11'd0,11'h000, 11'd2,11'd0,16'd1,T));
    apply_vec("fsop1", mk(T,F,T,T,3'd0,8'h9A, F,F,11'd0,11'h000, 11'd2,11'd0,16'd1,F));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
